// File: rtl/sdram_client_port.sv
// sdram_client_port: one SDRAM master's side of the arbiter req/ack handshake.
// Takes one burst job, requests the grant, then issues per-beat commands, drains read returns and releases req.
module sdram_client_port #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              usr_valid,
  output logic              usr_ready,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [LEN_W-1:0]  usr_len,
  input  logic [DATA_W-1:0] usr_wdata,
  input  logic              usr_wvalid,
  output logic              usr_wready,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  output logic              usr_done,
  output logic              usr_err,
  output logic              req,
  input  logic              ack,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);
  typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, RELEASE} state_t;
  state_t              r_state;
  logic                r_we;
  logic                r_req;
  logic                r_done;
  logic                r_err;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W:0]      r_total;
  logic [LEN_W:0]      r_issued;
  logic [LEN_W:0]      r_returned;
  logic                w_fire;
  logic                w_ret;
  logic                w_last;
  logic [LEN_W:0]      w_ret_cnt;
  assign usr_ready     = r_state == IDLE;
  assign mem_cmd_valid = (r_state == XFER) && ack && (usr_wvalid || !r_we);
  assign w_fire        = mem_cmd_valid && mem_cmd_ready;
  // returns count in XFER too, including the cycle a command fires
  assign w_ret         = mem_rvalid && !r_we && (r_state == XFER || r_state == DRAIN);
  assign w_ret_cnt     = r_returned + {{LEN_W{1'b0}}, w_ret};
  assign w_last        = w_fire && (r_issued + (LEN_W+1)'(1) == r_total);
  assign usr_wready    = w_fire && r_we;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = usr_wdata;
  assign usr_rdata     = r_rdata;
  assign usr_rvalid    = r_rvalid;
  assign usr_done      = r_done;
  assign usr_err       = r_err;
  assign req           = r_req;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_total    <= '0;
      r_issued   <= '0;
      r_returned <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= w_ret;
      if (w_ret) r_rdata <= mem_rdata;
      if (w_ret) r_returned <= w_ret_cnt;
      if (w_fire) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_issued <= r_issued + (LEN_W+1)'(1);
      end
      case (r_state)
        IDLE: if (usr_valid) begin
          r_we       <= usr_we;
          r_addr     <= usr_addr;
          r_total    <= (LEN_W+1)'(usr_len) + (LEN_W+1)'(1);
          r_issued   <= '0;
          r_returned <= '0;
          r_err      <= 1'b0;
          r_req      <= 1'b1;
          r_state    <= REQ;
        end
        REQ: if (ack) r_state <= XFER;
        XFER: if (!ack) begin
          r_err   <= 1'b1;
          r_req   <= 1'b0;
          r_state <= RELEASE;
        end else if (w_last) begin
          r_req   <= !(r_we || w_ret_cnt == r_total);
          r_state <= (r_we || w_ret_cnt == r_total) ? RELEASE : DRAIN;
        end
        DRAIN: if (!ack) begin
          r_err   <= 1'b1;
          r_req   <= 1'b0;
          r_state <= RELEASE;
        end else if (w_ret_cnt == r_total) begin
          r_req   <= 1'b0;
          r_state <= RELEASE;
        end
        RELEASE: if (!ack) begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_client_port.sv
// tb_sdram_client_port: randomized bench with arbiter/controller models and a burst-level reference.
// Expected beats are derived from the job (addr+i mod 2^24, i-th write word, read data as a function of address).
module tb_sdram_client_port;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic usr_valid = 1'b0, usr_we = 1'b0, usr_wvalid = 1'b0;
  logic [23:0] usr_addr = '0;
  logic [7:0]  usr_len = '0;
  logic [15:0] usr_wdata = '0;
  logic ack = 1'b0, mem_cmd_ready = 1'b0, mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic usr_ready, usr_wready, usr_rvalid, usr_done, usr_err, req, mem_cmd_valid, mem_we;
  logic [15:0] usr_rdata, mem_wdata;
  logic [23:0] mem_addr;

  sdram_client_port dut (
    .clk(clk), .rst_n(rst_n), .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_we(usr_we),
    .usr_addr(usr_addr), .usr_len(usr_len), .usr_wdata(usr_wdata), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_done(usr_done),
    .usr_err(usr_err), .req(req), .ack(ack), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  typedef struct {int due; logic [15:0] data;} ret_t;
  typedef struct {logic we; logic [23:0] addr; logic [15:0] data;} cmd_t;
  ret_t pend[$];
  cmd_t q_cmd[$];
  logic [15:0] q_rd[$];
  logic [15:0] wdata [0:511];
  int cyc, req_cnt, low_cnt, fired_cnt, wr_idx, done_cnt, done_cyc, ackfall_cyc, viol, low_run;
  int ack_dly = 2, rel_lag = 0, drop_after = -1, lat_min = 1, lat_max = 1, last_low_run = -1, drain_req_low;
  bit rdy_rand, wv_rand, spur, dropped, last_err, done_req, done_rdy;
  int checks, failures;
  ret_t r_pop, r_new;
  cmd_t c_new;

  function automatic logic [15:0] rd_model(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h5A3C;
  endfunction

  function automatic int cmd_errs(input bit we, input logic [23:0] a, input int n);
    int e = 0;
    logic [23:0] x;
    if (q_cmd.size() != n) e++;
    for (int i = 0; i < n && i < q_cmd.size(); i++) begin
      x = a + 24'(i);
      if (q_cmd[i].we !== we || q_cmd[i].addr !== x || q_cmd[i].data !== (we ? wdata[i] : 16'h0)) e++;
    end
    return e;
  endfunction

  function automatic int rd_errs(input logic [23:0] a, input int n);
    int e = 0;
    if (q_rd.size() != n) e++;
    for (int i = 0; i < n && i < q_rd.size(); i++)
      if (q_rd[i] !== rd_model(a + 24'(i))) e++;
    return e;
  endfunction

  // arbiter + controller + user write-data source, all changing just after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (req) begin req_cnt++; low_cnt = 0; end
    else begin req_cnt = 0; low_cnt++; dropped = 1'b0; end
    if (!req && ack && low_cnt > rel_lag) begin ack = 1'b0; ackfall_cyc = cyc; end
    else if (req && !ack && !dropped && req_cnt > ack_dly) ack = 1'b1;
    if (req && ack && drop_after >= 0 && fired_cnt >= drop_after) begin ack = 1'b0; dropped = 1'b1; ackfall_cyc = cyc; end
    mem_cmd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    usr_wvalid = wv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    usr_wdata = wdata[wr_idx];
    mem_rvalid = spur;
    mem_rdata = 16'($urandom);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r_pop = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata = r_pop.data;
    end
  end

  // mid-cycle observer
  always @(negedge clk) if (rst_n) begin
    if (mem_cmd_valid && !ack) viol++;
    if (usr_wready !== (mem_cmd_valid && mem_cmd_ready && mem_we)) viol++;
    if (mem_cmd_valid && mem_cmd_ready) begin
      c_new.we = mem_we;
      c_new.addr = mem_addr;
      c_new.data = mem_we ? mem_wdata : 16'h0;
      q_cmd.push_back(c_new);
      fired_cnt++;
      if (!mem_we) begin
        r_new.due = cyc + $urandom_range(lat_min, lat_max);
        r_new.data = rd_model(mem_addr);
        pend.push_back(r_new);
      end
    end
    if (usr_wready) wr_idx++;
    if (mem_rvalid && !spur && !req) drain_req_low++;
    if (usr_rvalid) q_rd.push_back(usr_rdata);
    if (req && low_run > 0) last_low_run = low_run;
    low_run = req ? 0 : low_run + 1;
    if (usr_done) begin
      done_cnt++;
      last_err = usr_err;
      done_cyc = cyc;
      done_req = req;
      done_rdy = usr_ready;
    end
  end

  task automatic run_job(input bit we, input logic [23:0] addr, input logic [7:0] len, input bit wait_done, output bit tmo);
    int n0;
    for (int i = 0; i < 512; i++) wdata[i] = 16'($urandom);
    q_cmd.delete();
    q_rd.delete();
    fired_cnt = 0;
    wr_idx = 0;
    n0 = done_cnt;
    @(posedge clk);
    #2;
    usr_valid = 1'b1; usr_we = we; usr_addr = addr; usr_len = len;
    @(negedge clk);
    for (int i = 0; i < 1000 && !usr_ready; i++) @(negedge clk);
    tmo = !usr_ready;
    @(posedge clk);
    #2 usr_valid = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < 5000 && done_cnt == n0; i++) @(negedge clk);
      tmo = tmo || (done_cnt == n0);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
    checks++; if (mem_cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b want=0", mem_cmd_valid); end
    checks++; if (usr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", usr_ready); end
    checks++; if (usr_done !== 1'b0 || usr_err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b want=00", usr_done, usr_err); end
    checks++; if (usr_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want=0", usr_rvalid); end
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    bit tmo;
    int e;
    ack_dly = 2; rel_lag = 2; rdy_rand = 0; wv_rand = 0; drop_after = -1;
    run_job(1'b1, 24'h000010, 8'd3, 1'b1, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL write_timeout got=timeout want=done"); end
    e = cmd_errs(1'b1, 24'h000010, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL write_beats errs=%0d beats=%0d want errs=0 beats=4", e, q_cmd.size()); end
    checks++; if (done_cyc - ackfall_cyc !== 1) begin failures++; $display("FAIL write_done_lat got=%0d want=1", done_cyc - ackfall_cyc); end
    checks++; if (done_req !== 1'b0 || done_rdy !== 1'b1) begin failures++; $display("FAIL write_done_state req=%b ready=%b want req=0 ready=1", done_req, done_rdy); end
  endtask

  task automatic test_read;
    bit tmo;
    int e;
    logic [23:0] a;
    a = 24'($urandom);
    lat_min = 3; lat_max = 3; rel_lag = 0; drain_req_low = 0;
    run_job(1'b0, a, 8'd0, 1'b1, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL read_timeout got=timeout want=done"); end
    e = cmd_errs(1'b0, a, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL read_cmds errs=%0d want=0", e); end
    e = rd_errs(a, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL read_data errs=%0d rvalids=%0d want errs=0 rvalids=1", e, q_rd.size()); end
    checks++; if (drain_req_low !== 0) begin failures++; $display("FAIL read_drain_req low_at_return=%0d want=0", drain_req_low); end
  endtask

  task automatic test_backpressure;
    bit tmo;
    int e;
    logic [23:0] a;
    rdy_rand = 1; wv_rand = 1; lat_min = 1; lat_max = 4;
    a = 24'($urandom);
    run_job(1'b1, a, 8'd15, 1'b1, tmo);
    e = cmd_errs(1'b1, a, 16) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL bp_write errs=%0d want=0", e); end
    a = 24'($urandom);
    run_job(1'b0, a, 8'd15, 1'b1, tmo);
    e = cmd_errs(1'b0, a, 16) + rd_errs(a, 16) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL bp_read errs=%0d want=0", e); end
  endtask

  task automatic test_wrap;
    bit tmo;
    int e;
    rdy_rand = 0; wv_rand = 0;
    run_job(1'b1, 24'hFFFFFE, 8'd3, 1'b1, tmo);
    e = cmd_errs(1'b1, 24'hFFFFFE, 4) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL wrap_beats errs=%0d want=0", e); end
    checks++;
    if (q_cmd.size() < 3 || q_cmd[2].addr !== 24'h000000) begin
      failures++; $display("FAIL wrap_third_addr beats=%0d want third addr=000000", q_cmd.size());
    end
  endtask

  task automatic test_grant_loss;
    bit tmo;
    int e;
    logic [23:0] a;
    a = 24'($urandom);
    rdy_rand = 0; wv_rand = 0; rel_lag = 0; drop_after = 2;
    run_job(1'b1, a, 8'd7, 1'b1, tmo);
    drop_after = -1;
    e = cmd_errs(1'b1, a, 2) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL abort_beats errs=%0d beats=%0d want errs=0 beats=2", e, q_cmd.size()); end
    checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b want=1", last_err); end
    repeat (2) @(negedge clk);
    checks++; if (usr_err !== 1'b1) begin failures++; $display("FAIL abort_err_held got=%b want=1", usr_err); end
    a = 24'($urandom);
    run_job(1'b1, a, 8'd1, 1'b1, tmo);
    e = cmd_errs(1'b1, a, 2) + int'(tmo);
    checks++; if (e !== 0 || last_err !== 1'b0) begin failures++; $display("FAIL abort_next errs=%0d err=%b want errs=0 err=0", e, last_err); end
  endtask

  task automatic test_max_len;
    bit tmo;
    int e;
    logic [23:0] a;
    a = 24'($urandom);
    rdy_rand = 1; wv_rand = 1;
    run_job(1'b1, a, 8'd255, 1'b1, tmo);
    e = cmd_errs(1'b1, a, 256) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL max_len errs=%0d beats=%0d want errs=0 beats=256", e, q_cmd.size()); end
  endtask

  task automatic test_reset_mid;
    bit tmo;
    rdy_rand = 1; wv_rand = 0; lat_min = 1; lat_max = 4;
    run_job(1'b0, 24'($urandom), 8'd31, 1'b0, tmo);
    for (int i = 0; i < 500 && fired_cnt < 3; i++) @(negedge clk);
    checks++; if (fired_cnt < 3) begin failures++; $display("FAIL rst_mid_start fired=%0d want>=3", fired_cnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || mem_cmd_valid !== 1'b0 || usr_done !== 1'b0 || usr_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid req=%b cmd_valid=%b done=%b ready=%b want 0 0 0 1", req, mem_cmd_valid, usr_done, usr_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
    for (int i = 0; i < 20 && ack; i++) @(negedge clk);
    checks++; if (usr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b want=1", usr_ready); end
  endtask

  task automatic test_back_to_back;
    bit tmo;
    int e;
    logic [23:0] a0, a1;
    rdy_rand = 0; wv_rand = 0; rel_lag = 0; ack_dly = 0;
    a0 = 24'($urandom);
    a1 = 24'($urandom);
    run_job(1'b1, a0, 8'd2, 1'b1, tmo);
    e = cmd_errs(1'b1, a0, 3) + int'(tmo);
    last_low_run = -1;
    run_job(1'b0, a1, 8'd1, 1'b1, tmo);
    e = e + cmd_errs(1'b0, a1, 2) + rd_errs(a1, 2) + int'(tmo);
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b_jobs errs=%0d want=0", e); end
    checks++; if (last_low_run < 1) begin failures++; $display("FAIL b2b_req_gap got=%0d want>=1", last_low_run); end
  endtask

  task automatic test_spurious;
    int n;
    q_rd.delete();
    @(posedge clk);
    #2 spur = 1'b1;
    repeat (5) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    n = q_rd.size();
    checks++; if (n !== 0) begin failures++; $display("FAIL idle_rvalid got=%0d want=0", n); end
  endtask

  task automatic test_random;
    bit tmo, we;
    int e;
    logic [23:0] a;
    logic [7:0] len;
    for (int j = 0; j < 20; j++) begin
      we = 1'($urandom_range(0, 1));
      a = (j % 5 == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15)) : 24'($urandom);
      len = 8'($urandom_range(0, 31));
      rdy_rand = 1'($urandom_range(0, 1)); wv_rand = 1'($urandom_range(0, 1));
      lat_min = 1; lat_max = $urandom_range(1, 5);
      ack_dly = $urandom_range(0, 5); rel_lag = $urandom_range(0, 3);
      run_job(we, a, len, 1'b1, tmo);
      e = cmd_errs(we, a, int'(len) + 1) + (we ? 0 : rd_errs(a, int'(len) + 1)) + int'(tmo) + int'(last_err);
      checks++; if (e !== 0) begin failures++; $display("FAIL rand_job%0d we=%b len=%0d errs=%0d want=0", j, we, len, e); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_wrap();
    test_grant_loss();
    test_max_len();
    test_reset_mid();
    test_back_to_back();
    test_spurious();
    test_random();
    checks++; if (viol !== 0) begin failures++; $display("FAIL protocol_violations got=%0d want=0", viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
